// File: rtl/tx_lane_framer.sv
// Transmit framer and lane mux: maps symbol-coded beats onto per-lane 8b symbols with D/K flags,
// fills gaps with IDL or PAD, and inserts SKP ordered sets on a programmable interval.
module tx_lane_framer #(
  parameter int NUM_LANES    = 4,
  parameter int SKP_INTERVAL = 1180
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [8*NUM_LANES-1:0] i_data,
  input  logic [3*NUM_LANES-1:0] i_code,
  input  logic                   i_skp_req,
  output logic [8*NUM_LANES-1:0] o_sym,
  output logic [NUM_LANES-1:0]   o_dk,
  output logic                   o_underrun,
  output logic                   o_err
);

  localparam int            CW      = $clog2(SKP_INTERVAL);
  localparam logic [CW-1:0] CNT_MAX = CW'(SKP_INTERVAL - 1);

  localparam logic [7:0] SYM_STP = 8'hFB;
  localparam logic [7:0] SYM_SDP = 8'h5C;
  localparam logic [7:0] SYM_END = 8'hFD;
  localparam logic [7:0] SYM_EDB = 8'hFE;
  localparam logic [7:0] SYM_PAD = 8'hF7;
  localparam logic [7:0] SYM_COM = 8'hBC;
  localparam logic [7:0] SYM_SKP = 8'h1C;
  localparam logic [7:0] SYM_IDL = 8'h7C;

  typedef enum logic [1:0] {RUN, SKP1, SKP2, SKP3} state_t;

  state_t                 state;
  logic [CW-1:0]          skp_cnt;
  logic                   skp_pending;
  logic                   in_pkt;
  logic                   go_skp;

  logic [8*NUM_LANES-1:0] beat_sym;
  logic [NUM_LANES-1:0]   beat_dk;
  logic                   beat_err;
  logic                   beat_mark;
  logic                   beat_start;

  assign go_skp  = (state == RUN) && skp_pending && !in_pkt;
  assign o_ready = !i_rst && (state == RUN) && !go_skp;

  // Lanes are scanned low to high so the highest-indexed framing code decides in_pkt.
  always_comb begin
    beat_sym   = '0;
    beat_dk    = '0;
    beat_err   = 1'b0;
    beat_mark  = 1'b0;
    beat_start = 1'b0;
    for (int j = 0; j < NUM_LANES; j++) begin
      case (i_code[3*j +: 3])
        3'd0: begin
          beat_sym[8*j +: 8] = i_data[8*j +: 8];
          beat_dk[j]         = 1'b1;
        end
        3'd1: begin
          beat_sym[8*j +: 8] = SYM_STP;
          beat_mark          = 1'b1;
          beat_start         = 1'b1;
        end
        3'd2: begin
          beat_sym[8*j +: 8] = SYM_SDP;
          beat_mark          = 1'b1;
          beat_start         = 1'b1;
        end
        3'd3: begin
          beat_sym[8*j +: 8] = SYM_END;
          beat_mark          = 1'b1;
          beat_start         = 1'b0;
        end
        3'd4: begin
          beat_sym[8*j +: 8] = SYM_EDB;
          beat_mark          = 1'b1;
          beat_start         = 1'b0;
        end
        3'd5: beat_sym[8*j +: 8] = SYM_PAD;
        default: begin
          beat_sym[8*j +: 8] = SYM_PAD;
          beat_err           = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= RUN;
      skp_cnt     <= '0;
      skp_pending <= 1'b0;
      in_pkt      <= 1'b0;
      o_sym       <= '0;
      o_dk        <= '0;
      o_underrun  <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      o_underrun <= 1'b0;
      o_err      <= 1'b0;
      case (state)
        RUN: begin
          if (go_skp) begin
            o_sym <= {NUM_LANES{SYM_COM}};
            o_dk  <= '0;
            state <= SKP1;
          end else if (i_valid) begin
            o_sym <= beat_sym;
            o_dk  <= beat_dk;
            o_err <= beat_err;
            if (beat_mark) in_pkt <= beat_start;
          end else if (in_pkt) begin
            o_sym      <= {NUM_LANES{SYM_PAD}};
            o_dk       <= '0;
            o_underrun <= 1'b1;
          end else begin
            o_sym <= {NUM_LANES{SYM_IDL}};
            o_dk  <= '0;
          end
        end
        SKP1: begin
          o_sym <= {NUM_LANES{SYM_SKP}};
          o_dk  <= '0;
          state <= SKP2;
        end
        SKP2: begin
          o_sym <= {NUM_LANES{SYM_SKP}};
          o_dk  <= '0;
          state <= SKP3;
        end
        SKP3: begin
          o_sym <= {NUM_LANES{SYM_SKP}};
          o_dk  <= '0;
          state <= RUN;
        end
        default: state <= RUN;
      endcase

      // The interval counter rests at zero through the ordered set, so it measures the gap between sets.
      if (go_skp || state != RUN)
        skp_cnt <= '0;
      else if (skp_cnt != CNT_MAX)
        skp_cnt <= skp_cnt + 1'b1;

      if (go_skp)
        skp_pending <= 1'b0;
      else if (i_skp_req || skp_cnt == CNT_MAX)
        skp_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tx_lane_framer.sv
// Bench for tx_lane_framer: directed beats checked against a cycle-level behavioural model
// every cycle, plus hand-computed literal expectations at key points.
module tb_tx_lane_framer;

  localparam int NL = 4;
  localparam int SI = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            valid = 1'b0;
  logic            skp_req = 1'b0;
  logic [8*NL-1:0] data = '0;
  logic [3*NL-1:0] code = '0;
  logic            ready;
  logic [8*NL-1:0] sym;
  logic [NL-1:0]   dk;
  logic            underrun;
  logic            err;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  tx_lane_framer #(.NUM_LANES(NL), .SKP_INTERVAL(SI)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_valid    (valid),
    .o_ready    (ready),
    .i_data     (data),
    .i_code     (code),
    .i_skp_req  (skp_req),
    .o_sym      (sym),
    .o_dk       (dk),
    .o_underrun (underrun),
    .o_err      (err)
  );

  // Model: 'since' counts non-SKP cycles since reset or the last ordered set; a set is due
  // once it reaches SKP_INTERVAL or a request was seen, and starts when no packet is open.
  int              since;
  int              skp_left;
  bit              req_seen;
  bit              pkt_open;
  logic [8*NL-1:0] m_sym;
  logic [NL-1:0]   m_dk;
  bit              m_und;
  bit              m_err;

  function automatic bit m_due();
    return (since >= SI) || req_seen;
  endfunction

  function automatic bit m_ready();
    if (rst) return 1'b0;
    return (skp_left == 0) && !(m_due() && !pkt_open);
  endfunction

  function automatic logic [7:0] k_byte(input int c);
    case (c)
      1: return 8'hFB;
      2: return 8'h5C;
      3: return 8'hFD;
      4: return 8'hFE;
      default: return 8'hF7;
    endcase
  endfunction

  always @(posedge clk) begin : model
    bit go;
    bit acc;
    bit in_set;
    bit found;
    int c;
    if (rst) begin
      since = 0; skp_left = 0; req_seen = 1'b0; pkt_open = 1'b0;
      m_sym = '0; m_dk = '0; m_und = 1'b0; m_err = 1'b0;
    end else begin
      go     = (skp_left == 0) && m_due() && !pkt_open;
      acc    = valid && m_ready();
      in_set = (skp_left > 0);
      m_und  = 1'b0;
      m_err  = 1'b0;
      if (in_set) begin
        m_sym = {NL{8'h1C}}; m_dk = '0; skp_left = skp_left - 1;
      end else if (go) begin
        m_sym = {NL{8'hBC}}; m_dk = '0; skp_left = 3;
      end else if (acc) begin
        for (int j = 0; j < NL; j++) begin
          c = int'(code[3*j +: 3]);
          if (c == 0) begin
            m_sym[8*j +: 8] = data[8*j +: 8]; m_dk[j] = 1'b1;
          end else begin
            m_sym[8*j +: 8] = k_byte(c); m_dk[j] = 1'b0;
          end
          if (c >= 6) m_err = 1'b1;
        end
        found = 1'b0;
        for (int j = NL - 1; j >= 0; j--) begin
          c = int'(code[3*j +: 3]);
          if (!found && c >= 1 && c <= 4) begin
            found = 1'b1;
            pkt_open = (c <= 2);
          end
        end
      end else if (pkt_open) begin
        m_sym = {NL{8'hF7}}; m_dk = '0; m_und = 1'b1;
      end else begin
        m_sym = {NL{8'h7C}}; m_dk = '0;
      end
      if (go) begin
        since = 0; req_seen = 1'b0;
      end else begin
        if (skp_req) req_seen = 1'b1;
        if (!in_set) since = since + 1;
      end
    end
  end

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkVal("cyc_sym", 64'(sym), 64'(m_sym));
      checkVal("cyc_dk", 64'(dk), 64'(m_dk));
      checkVal("cyc_underrun", 64'(underrun), 64'(m_und));
      checkVal("cyc_err", 64'(err), 64'(m_err));
      checkVal("cyc_ready", 64'(ready), 64'(m_ready()));
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] esym, input logic [3:0] edk,
                             input bit eund, input bit eerr);
    checkVal({name, "_sym"}, 64'(sym), 64'(esym));
    checkVal({name, "_dk"}, 64'(dk), 64'(edk));
    checkVal({name, "_underrun"}, 64'(underrun), 64'(eund));
    checkVal({name, "_err"}, 64'(err), 64'(eerr));
  endtask

  task automatic checkReady(input string name, input bit exp);
    checkVal(name, 64'(ready), 64'(exp));
  endtask

  task automatic applyStimulus(input bit v, input logic [31:0] d, input logic [11:0] c, input bit r);
    valid = v; data = d; code = c; skp_req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, '0, '0, 1'b0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  localparam logic [31:0] IDL4 = 32'h7C7C7C7C;
  localparam logic [31:0] PAD4 = 32'hF7F7F7F7;
  localparam logic [31:0] COM4 = 32'hBCBCBCBC;
  localparam logic [31:0] SKP4 = 32'h1C1C1C1C;

  initial begin
    // Reset state and idle, then the scheduled set with a request absorbed on its start cycle
    rst = 1'b1;
    idle(2);
    checkOutput("rst", 32'h0, 4'h0, 1'b0, 1'b0);
    checkReady("rst_ready", 1'b0);
    check_en = 1'b1;
    rst = 1'b0;
    idle(1);
    checkOutput("idle", IDL4, 4'h0, 1'b0, 1'b0);
    checkReady("idle_ready", 1'b1);
    idle(15);
    checkReady("due_ready", 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1);
    checkOutput("com", COM4, 4'h0, 1'b0, 1'b0);
    idle(1);
    checkOutput("skp1", SKP4, 4'h0, 1'b0, 1'b0);
    checkReady("skp_ready", 1'b0);
    idle(2);
    checkOutput("skp3", SKP4, 4'h0, 1'b0, 1'b0);
    checkReady("after_skp_ready", 1'b1);
    idle(1);
    checkOutput("req_absorbed", IDL4, 4'h0, 1'b0, 1'b0);
    idle(15);
    checkOutput("gap_end", IDL4, 4'h0, 1'b0, 1'b0);
    idle(1);
    checkOutput("com2", COM4, 4'h0, 1'b0, 1'b0);
    idle(3);

    // Single framed beat
    doReset();
    applyStimulus(1'b1, 32'h005AA500, 12'h601, 1'b0);
    checkOutput("beat", 32'hFD5AA5FB, 4'b0110, 1'b0, 1'b0);
    idle(1);
    checkOutput("beat_after", IDL4, 4'h0, 1'b0, 1'b0);

    // Underrun inside a packet
    doReset();
    applyStimulus(1'b1, 32'h33221100, 12'h001, 1'b0);
    checkOutput("stp", 32'h332211FB, 4'b1110, 1'b0, 1'b0);
    idle(1);
    checkOutput("und1", PAD4, 4'h0, 1'b1, 1'b0);
    idle(1);
    checkOutput("und2", PAD4, 4'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h00CCBBAA, 12'h600, 1'b0);
    checkOutput("end", 32'hFDCCBBAA, 4'b0111, 1'b0, 1'b0);
    idle(1);
    checkOutput("end_after", IDL4, 4'h0, 1'b0, 1'b0);

    // Reserved code
    doReset();
    applyStimulus(1'b1, 32'h44332211, 12'h007, 1'b0);
    checkOutput("rsvd", 32'h443322F7, 4'b1110, 1'b0, 1'b1);
    idle(1);
    checkOutput("rsvd_after", IDL4, 4'h0, 1'b0, 1'b0);

    // Requested SKP
    doReset();
    idle(2);
    applyStimulus(1'b0, '0, '0, 1'b1);
    idle(1);
    checkOutput("req_com", COM4, 4'h0, 1'b0, 1'b0);
    idle(3);

    // Several framing codes in one beat: the highest lane decides
    doReset();
    applyStimulus(1'b1, 32'hDD00BB00, 12'h043, 1'b0);
    checkOutput("mix_a", 32'hDDFBBBFD, 4'b1010, 1'b0, 1'b0);
    idle(1);
    checkOutput("mix_a_open", PAD4, 4'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h0, 12'h9AA, 1'b0);
    checkOutput("mix_c", 32'hFEF7F75C, 4'b0000, 1'b0, 1'b1);
    idle(1);
    checkOutput("mix_c_closed", IDL4, 4'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h77660055, 12'h010, 1'b0);
    checkOutput("mix_e", 32'h77665C55, 4'b1101, 1'b0, 1'b0);
    idle(1);
    checkOutput("mix_e_open", PAD4, 4'h0, 1'b1, 1'b0);

    // SKP falls due mid-packet and waits for the END beat
    doReset();
    idle(14);
    applyStimulus(1'b1, 32'h04030201, 12'h001, 1'b0);
    applyStimulus(1'b1, 32'h14131211, 12'h000, 1'b0);
    applyStimulus(1'b1, 32'h24232221, 12'h000, 1'b0);
    checkOutput("defer_data", 32'h24232221, 4'b1111, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h34333231, 12'h000, 1'b0);
    applyStimulus(1'b1, 32'h00434241, 12'h600, 1'b0);
    checkOutput("defer_end", 32'hFD434241, 4'b0111, 1'b0, 1'b0);
    checkReady("defer_ready", 1'b0);
    applyStimulus(1'b1, 32'h54535251, 12'h000, 1'b0);
    checkOutput("defer_com", COM4, 4'h0, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b1, 32'h54535251, 12'h000, 1'b0);
    checkOutput("defer_skp3", SKP4, 4'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h54535251, 12'h000, 1'b0);
    checkOutput("defer_resume", 32'h54535251, 4'b1111, 1'b0, 1'b0);
    idle(1);
    checkOutput("defer_once", IDL4, 4'h0, 1'b0, 1'b0);

    // Reset while in SKP2
    doReset();
    idle(17);
    checkOutput("pre_rst_com", COM4, 4'h0, 1'b0, 1'b0);
    idle(1);
    rst = 1'b1;
    idle(1);
    checkOutput("rst_skp", 32'h0, 4'h0, 1'b0, 1'b0);
    checkReady("rst_skp_ready", 1'b0);
    rst = 1'b0;
    idle(1);
    checkOutput("rst_idl", IDL4, 4'h0, 1'b0, 1'b0);
    idle(3);
    checkOutput("rst_no_skp", IDL4, 4'h0, 1'b0, 1'b0);

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
